// File: rtl/sid_bus_pkg.sv
// Shared definitions for the SID register-write bus.
// Contents: bus field widths, voice/filter register address map, the filter
// bank voice code, the write-scheduler state type and small helpers used by
// the scheduler and its arbiter.
package sid_bus_pkg;

    localparam int VOICE_W = 2;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 8;

    // Voice select value that addresses the filter bank instead of a voice.
    localparam logic [VOICE_W-1:0] VOICE_FILT = 2'd3;

    // Per-voice register map.
    localparam logic [ADDR_W-1:0] REG_FREQ_LO = 3'd0;
    localparam logic [ADDR_W-1:0] REG_FREQ_HI = 3'd1;
    localparam logic [ADDR_W-1:0] REG_PW_LO   = 3'd2;
    localparam logic [ADDR_W-1:0] REG_PW_HI   = 3'd3;
    localparam logic [ADDR_W-1:0] REG_AD      = 3'd4;
    localparam logic [ADDR_W-1:0] REG_SR      = 3'd5;
    localparam logic [ADDR_W-1:0] REG_WAV     = 3'd6;

    // Filter-bank register map; anything above FILT_ADDR_MAX does not exist.
    localparam logic [ADDR_W-1:0] REG_FC_LO    = 3'd0;
    localparam logic [ADDR_W-1:0] REG_FC_HI    = 3'd1;
    localparam logic [ADDR_W-1:0] REG_RES_FILT = 3'd2;
    localparam logic [ADDR_W-1:0] REG_MODE_VOL = 3'd3;
    localparam logic [ADDR_W-1:0] FILT_ADDR_MAX = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } wr_state_t;

    // Width of a requester index; a single requester still gets one bit.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Writes to non-existent filter-bank registers must never reach the core.
    function automatic logic is_illegal(input logic [VOICE_W-1:0] voice,
                                        input logic [ADDR_W-1:0]  addr);
        return (voice == VOICE_FILT) && (addr > FILT_ADDR_MAX);
    endfunction

endpackage

// File: rtl/sid_rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   valid     - request vector, one bit per requester
//   ptr       - highest-priority requester index (register lives in parent)
//   grant     - one-hot grant, all zero when nothing is valid
//   grant_idx - index of the granted requester (0 when nothing is valid)
module sid_rr_arbiter
    import sid_bus_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]          valid,
    input  logic [id_w(NUM_REQ)-1:0]    ptr,
    output logic [NUM_REQ-1:0]          grant,
    output logic [id_w(NUM_REQ)-1:0]    grant_idx
);

    localparam int ID_W = id_w(NUM_REQ);

    logic found;

    // Scan from ptr upward, wrapping; first valid requester wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = 0; off < NUM_REQ; off++) begin
            if (!found && valid[(int'(ptr) + off) % NUM_REQ]) begin
                found                                 = 1'b1;
                grant[(int'(ptr) + off) % NUM_REQ]    = 1'b1;
                grant_idx                             = ID_W'((int'(ptr) + off) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/sid_reg_write_scheduler.sv
// Shares the SID core register-write port between NUM_REQ requesters.
// Arbitrates round-robin, latches one request and plays out the
// setup / strobe / hold write cycle; writes to non-existent filter-bank
// registers are accepted and dropped with a one-cycle err_illegal pulse.
// Ports:
//   clk, rst                         - clock, async active-high reset
//   req_valid/req_ready              - per-requester handshake
//   req_voice/req_addr/req_data      - packed per-requester write fields
//   bus_voice/bus_addr/bus_data      - registered fields to the core
//   bus_wr                           - write strobe to the core
//   busy                             - write cycle in progress
//   grant_id                         - last accepted requester
//   err_illegal                      - illegal write dropped
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | arbitrating; req_ready live; bus fields hold last write
// ST_SETUP  | fields driven, strobe low, SETUP_CYC cycles
// ST_STROBE | bus_wr high, STROBE_CYC cycles
// ST_HOLD   | strobe low, fields held, HOLD_CYC cycles, then ST_IDLE
module sid_reg_write_scheduler
    import sid_bus_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 1,
    parameter int HOLD_CYC   = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [VOICE_W*NUM_REQ-1:0]  req_voice,
    input  logic [ADDR_W*NUM_REQ-1:0]   req_addr,
    input  logic [DATA_W*NUM_REQ-1:0]   req_data,
    output logic [VOICE_W-1:0]          bus_voice,
    output logic [ADDR_W-1:0]           bus_addr,
    output logic [DATA_W-1:0]           bus_data,
    output logic                        bus_wr,
    output logic                        busy,
    output logic [id_w(NUM_REQ)-1:0]    grant_id,
    output logic                        err_illegal
);

    localparam int ID_W    = id_w(NUM_REQ);
    localparam int CNT_MAX = (SETUP_CYC > STROBE_CYC)
                             ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                             : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    // Counters load length-1 and the state ends at terminal count zero.
    localparam logic [CNT_W-1:0] LD_SETUP  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] LD_STROBE = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_HOLD   = CNT_W'(HOLD_CYC - 1);

    wr_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     ptr_q, ptr_nxt;
    logic [ID_W-1:0]     grant_q;
    logic [VOICE_W-1:0]  voice_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_idx;
    logic [VOICE_W-1:0]  sel_voice;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic                accept;
    logic                illegal;

    sid_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .valid     (req_valid),
        .ptr       (ptr_q),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign req_ready = (state_q == ST_IDLE) ? arb_grant : '0;
    assign accept    = |req_ready;

    assign sel_voice = req_voice[arb_idx*VOICE_W +: VOICE_W];
    assign sel_addr  = req_addr[arb_idx*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[arb_idx*DATA_W +: DATA_W];
    assign illegal   = is_illegal(sel_voice, sel_addr);

    assign ptr_nxt   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && !illegal) begin
                    state_d = ST_SETUP;
                    cnt_d   = LD_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_STROBE;
                    cnt_d   = LD_STROBE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = LD_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Dropped illegal writes still advance the pointer so a requester that
    // keeps sending bad addresses cannot starve the others, but they leave
    // the bus fields untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            grant_q <= '0;
            voice_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && illegal;
            if (accept) begin
                grant_q <= arb_idx;
                ptr_q   <= ptr_nxt;
                if (!illegal) begin
                    voice_q <= sel_voice;
                    addr_q  <= sel_addr;
                    data_q  <= sel_data;
                end
            end
        end
    end

    // Decoded straight from the state register so an async reset drops the
    // strobe without waiting for a clock edge.
    assign bus_wr      = (state_q == ST_STROBE);
    assign busy        = (state_q != ST_IDLE);
    assign bus_voice   = voice_q;
    assign bus_addr    = addr_q;
    assign bus_data    = data_q;
    assign grant_id    = grant_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_sid_reg_write_scheduler.sv
module tb_sid_reg_write_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Default-timing instance.
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [3:0]  req_voice;
    logic [5:0]  req_addr;
    logic [15:0] req_data;
    logic [1:0]  bus_voice;
    logic [2:0]  bus_addr;
    logic [7:0]  bus_data;
    logic        bus_wr;
    logic        busy;
    logic [0:0]  grant_id;
    logic        err_illegal;

    // Stretched-timing instance.
    logic [1:0]  b_req_valid;
    logic [1:0]  b_req_ready;
    logic [3:0]  b_req_voice;
    logic [5:0]  b_req_addr;
    logic [15:0] b_req_data;
    logic [1:0]  b_bus_voice;
    logic [2:0]  b_bus_addr;
    logic [7:0]  b_bus_data;
    logic        b_bus_wr;
    logic        b_busy;
    logic [0:0]  b_grant_id;
    logic        b_err_illegal;

    typedef struct packed {
        logic [1:0] v;
        logic [2:0] a;
        logic [7:0] d;
        logic       id;
    } sb_t;

    sb_t sb[$];
    int  total = 0;
    int  bad   = 0;
    int  exp_ptr;
    int  g;
    sb_t e;

    logic [1:0] fv [0:10];
    logic [2:0] fa [0:10];
    logic [7:0] fd [0:10];

    always #5 clk = ~clk;

    sid_reg_write_scheduler #(
        .NUM_REQ(2), .SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_voice(req_voice), .req_addr(req_addr), .req_data(req_data),
        .bus_voice(bus_voice), .bus_addr(bus_addr), .bus_data(bus_data),
        .bus_wr(bus_wr), .busy(busy), .grant_id(grant_id),
        .err_illegal(err_illegal)
    );

    sid_reg_write_scheduler #(
        .NUM_REQ(2), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)
    ) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_voice(b_req_voice), .req_addr(b_req_addr), .req_data(b_req_data),
        .bus_voice(b_bus_voice), .bus_addr(b_bus_addr), .bus_data(b_bus_data),
        .bus_wr(b_bus_wr), .busy(b_busy), .grant_id(b_grant_id),
        .err_illegal(b_err_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [1:0] v, input logic [2:0] a,
                           input logic [7:0] d);
        req_valid[r]       = 1'b1;
        req_voice[r*2 +: 2] = v;
        req_addr[r*3 +: 3]  = a;
        req_data[r*8 +: 8]  = d;
    endtask

    task automatic check_fields(input string tag, input sb_t x);
        check({tag, "_voice"}, 32'(bus_voice), 32'(x.v));
        check({tag, "_addr"},  32'(bus_addr),  32'(x.a));
        check({tag, "_data"},  32'(bus_data),  32'(x.d));
        check({tag, "_gid"},   32'(grant_id),  32'(x.id));
    endtask

    // Called at the falling edge one cycle after the accept; returns at the
    // falling edge four cycles after the accept (back in IDLE).
    task automatic track_write();
        sb_t x;
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        x = sb.pop_front();
        check("setup_wr", 32'(bus_wr), 32'd0);
        check("setup_busy", 32'(busy), 32'd1);
        check("setup_ready", 32'(req_ready), 32'd0);
        check_fields("setup", x);
        @(negedge clk);
        check("strobe_wr", 32'(bus_wr), 32'd1);
        check("strobe_ready", 32'(req_ready), 32'd0);
        check_fields("strobe", x);
        @(negedge clk);
        check("hold_wr", 32'(bus_wr), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_ready", 32'(req_ready), 32'd0);
        check_fields("hold", x);
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_wr", 32'(bus_wr), 32'd0);
        check_fields("idle", x);
    endtask

    initial begin
        req_valid   = '0; req_voice   = '0; req_addr   = '0; req_data   = '0;
        b_req_valid = '0; b_req_voice = '0; b_req_addr = '0; b_req_data = '0;
        exp_ptr = 0;
        fv = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        fa = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd6};
        fd = '{8'h24, 8'h1D, 8'h00, 8'h08, 8'h09, 8'hF0, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h21};

        // Reset state.
        @(negedge clk); #1;
        check("rst_wr", 32'(bus_wr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data", 32'(bus_data), 32'd0);
        check("rst_addr", 32'(bus_addr), 32'd0);
        check("rst_voice", 32'(bus_voice), 32'd0);
        check("rst_gid", 32'(grant_id), 32'd0);
        check("rst_err", 32'(err_illegal), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Stretched timing: setup 2, strobe 3, hold 2.
        @(negedge clk);
        b_req_valid = 2'b01; b_req_voice[1:0] = 2'd2; b_req_addr[2:0] = 3'd4;
        b_req_data[7:0] = 8'h5A;
        #1 check("b_ready_acc", 32'(b_req_ready), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) b_req_data[7:0] = 8'h66;
            if (k < 8) begin
                check("b_wr", 32'(b_bus_wr), 32'((k >= 3) && (k <= 5)));
                check("b_busy", 32'(b_busy), 32'd1);
                check("b_ready_busy", 32'(b_req_ready), 32'd0);
            end else begin
                check("b_wr_end", 32'(b_bus_wr), 32'd0);
                check("b_busy_end", 32'(b_busy), 32'd0);
                check("b_ready_next", 32'(b_req_ready), 32'd1);
            end
            check("b_voice", 32'(b_bus_voice), 32'd2);
            check("b_addr", 32'(b_bus_addr), 32'd4);
            check("b_data", 32'(b_bus_data), 32'h5A);
        end
        b_req_valid = '0;

        // Single write on req0.
        @(negedge clk);
        set_req(0, 2'd0, 3'd0, 8'h24);
        #1 check("single_ready", 32'(req_ready), 32'd1);
        sb.push_back('{v: 2'd0, a: 3'd0, d: 8'h24, id: 1'b0});
        exp_ptr = 1;
        @(negedge clk);
        req_valid = '0;
        track_write();

        // Contention: both requesters valid continuously.
        set_req(0, 2'd1, 3'd2, 8'h11);
        set_req(1, 2'd1, 3'd2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            #1;
            g = exp_ptr;
            check("rr_ready", 32'(req_ready), 32'(1 << g));
            sb.push_back('{v: 2'd1, a: 3'd2, d: (g == 0) ? 8'h11 : 8'h22, id: g[0]});
            exp_ptr = (g + 1) % 2;
            @(negedge clk);
            track_write();
        end
        req_valid = '0;

        // Illegal filter address is dropped.
        @(negedge clk);
        set_req(0, 2'd3, 3'd5, 8'hFF);
        #1 check("ill_ready", 32'(req_ready), 32'd1);
        exp_ptr = 1;
        @(negedge clk);
        req_valid = '0;
        check("ill_err", 32'(err_illegal), 32'd1);
        check("ill_busy", 32'(busy), 32'd0);
        check("ill_wr", 32'(bus_wr), 32'd0);
        check("ill_gid", 32'(grant_id), 32'd0);
        @(negedge clk);
        check("ill_err_clr", 32'(err_illegal), 32'd0);
        check("ill_busy2", 32'(busy), 32'd0);
        check("ill_wr2", 32'(bus_wr), 32'd0);
        set_req(0, 2'd3, 3'd3, 8'h1F);
        #1 check("filt_ready", 32'(req_ready), 32'd1);
        sb.push_back('{v: 2'd3, a: 3'd3, d: 8'h1F, id: 1'b0});
        exp_ptr = 1;
        @(negedge clk);
        req_valid = '0;
        check("filt_err", 32'(err_illegal), 32'd0);
        track_write();

        // Reset in the middle of the strobe.
        @(negedge clk);
        set_req(0, 2'd0, 3'd4, 8'h3C);
        #1 check("rst_acc_ready", 32'(req_ready), 32'd1);
        sb.push_back('{v: 2'd0, a: 3'd4, d: 8'h3C, id: 1'b0});
        @(negedge clk);
        req_valid[0] = 1'b0;
        set_req(1, 2'd2, 3'd1, 8'h77);
        check("mid_setup_wr", 32'(bus_wr), 32'd0);
        @(negedge clk);
        check("mid_strobe_wr", 32'(bus_wr), 32'd1);
        e = sb.pop_front();
        check("mid_strobe_data", 32'(bus_data), 32'(e.d));
        #2 rst = 1'b1;
        #1;
        check("async_wr", 32'(bus_wr), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_data", 32'(bus_data), 32'd0);
        check("async_addr", 32'(bus_addr), 32'd0);
        check("async_gid", 32'(grant_id), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_ptr = 0;
        #1 check("post_rst_ready", 32'(req_ready), 32'd2);
        sb.push_back('{v: 2'd2, a: 3'd1, d: 8'h77, id: 1'b1});
        exp_ptr = 0;
        @(negedge clk);
        req_valid = '0;
        track_write();

        // Voice-0 saw plus filter setup, all through req1.
        for (int i = 0; i < 11; i++) begin
            set_req(1, fv[i], fa[i], fd[i]);
            #1 check("seq_ready", 32'(req_ready), 32'd2);
            sb.push_back('{v: fv[i], a: fa[i], d: fd[i], id: 1'b1});
            @(negedge clk);
            req_valid = '0;
            track_write();
        end

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
